rr_arb_mux: RTL
===============

// Module: rr_arb_mux
// PURPOSE
//  Parametrised N:1 data multiplexer with built-in round-robin arbitration and valid/ready handshake.
//  Successor of the fixed 2:1 select mux: the selector is generated internally, fairly, and held stable under back-pressure.
//  Merges multiple requesters (e.g. instr/data memory-side ports, debug port) onto one shared datapath/bus.
// PARAMETERS
//  Data_Width  32  width of each channel's data word
//  Num_Ch      4   number of input channels; legal 2..16
//  Idx_Width   $clog2(Num_Ch)  derived localparam; width of the grant index; not overridable
// PORTS
//  clk        in   1                 single clock; all state updates on rising edge
//  rst        in   1                 synchronous, active-high reset
//  in_valid   in   Num_Ch            per-channel request; bit i belongs to channel i
//  in_data    in   Num_Ch*Data_Width channel i occupies bits [i*Data_Width +: Data_Width]
//  in_ready   out  Num_Ch            one-hot (or zero) accept strobe back to the channels
//  out_valid  out  1                 output word available
//  out_data   out  Data_Width        selected word
//  out_ch     out  Idx_Width         index of the channel that sourced out_data
//  out_ready  in   1                 downstream accept
// BEHAVIOUR
//  Transfer: in on in_valid[i]&in_ready[i]; out on out_valid&out_ready.
//  Requester rule: once in_valid[i] is high, it stays high with in_data stable until accepted.
//  Arbitration: search starts at (last_ptr+1) mod Num_Ch and wraps; the first valid channel wins.
//   last_ptr updates to the winning index only on an output transfer.
//  FSM, 2 states:
//   ARB:  grant is computed combinationally each cycle.
//         out_valid&!out_ready -> HOLD, latching the grant index into lock_idx.
//   HOLD: grant is forced to lock_idx; out_data/out_ch stay stable; new requests are ignored.
//         out_ready -> ARB. Because of the requester rule, out_valid stays 1 throughout HOLD.
//  in_ready[i] = grant[i] & out_ready. At most one bit is set, never more.
//  Latency 0: out_data = in_data[grant], out_ch = grant index, out_valid = |in_valid (ARB) or 1 (HOLD).
//  No valid inputs: out_valid=0, in_ready=0, out_data=0, out_ch=0.
//  Single requester: it is granted every cycle, giving full throughput.
//  All Num_Ch valid with out_ready=1: grants rotate 0,1,2,...,Num_Ch-1,0,...
//  Reset: state=ARB, last_ptr=Num_Ch-1 (so channel 0 has first priority), lock_idx=0.
//   The output reset values above apply.
//   Reset mid-HOLD abandons the held word; no transfer is reported.
// CONFIGURATION
//  Macro RR_ARB_MUX_OUT_REG_EN.
//  Undefined: combinational output path as described, latency 0.
//  Defined: one output register stage.
//   - out_valid/out_data/out_ch are registered, latency 1 cycle, full throughput.
//   - The register loads when !out_valid | out_ready.
//   - in_ready[i] = grant[i] & (!out_valid | out_ready).
//   - Output back-pressure is absorbed by the register, so the HOLD state is unused (FSM stays in ARB).
//   - last_ptr updates on the input-side transfer.
//   - Reset clears out_valid, out_data and out_ch to 0.
// STRUCTURE
//  Shared package/header rr_arb_mux_defs.vh:
//   - Idx_Width clog2 function
//   - ARB/HOLD state encodings (1'b0/1'b1)
//  Sub-module rr_arbiter:
//   - Inputs: request vector and last_ptr. Outputs: one-hot grant and grant index.
//   - Purely combinational, using the double-width masked priority-encode scheme.
//  rr_arb_mux adds the FSM, last_ptr/lock registers, the data mux and the optional output stage.
// TESTING
//  1) rst=1 for 2 cycles, all in_valid=0 -> out_valid=0, in_ready=0, out_ch=0, out_data=0.
//  2) Num_Ch=4, all valid with data 0xA0..0xA3, out_ready=1 for 8 cycles
//     -> out_ch sequence 0,1,2,3,0,1,2,3 with matching data.
//  3) ch2 valid, data 0x55, out_ready=0 for 3 cycles; ch0 raises valid in cycle 2
//     -> out_ch=2, data 0x55 held stable, in_ready=0.
//     Then out_ready=1 -> ch2 accepted; next grant goes to ch0.
//  4) Only ch3 valid for 5 cycles, out_ready=1 -> 5 transfers, in_ready=4'b1000 every cycle.
//  5) rst asserted during HOLD -> next cycle: ARB, last_ptr=3; a fresh request on ch1 and ch0 grants ch0.
//  6) With RR_ARB_MUX_OUT_REG_EN defined, repeat 2) -> same sequence delayed one cycle.
//     out_ready toggling 1/0 -> no words lost or duplicated (scoreboard check).

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// Combinational round-robin arbiter: double-width masked priority encode,
// so the lowest request strictly above last_ptr wins, else the lowest overall.
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter  int Num_Ch    = 4,
  localparam int Idx_Width = idx_width(Num_Ch)
) (
  input  logic [Num_Ch-1:0]    req_i,
  input  logic [Idx_Width-1:0] last_ptr_i,
  output logic [Num_Ch-1:0]    gnt_o,
  output logic [Idx_Width-1:0] gnt_idx_o,
  output logic                 any_o
);

  logic [Num_Ch-1:0]   mask;
  logic [2*Num_Ch-1:0] dbl;

  always_comb begin
    for (int i = 0; i < Num_Ch; i++) mask[i] = (Idx_Width'(i) > last_ptr_i);
    // lower half holds requests above last_ptr, upper half is the wrapped copy
    dbl = {req_i, req_i & mask};
    gnt_idx_o = '0;
    for (int j = 2*Num_Ch-1; j >= 0; j--)
      if (dbl[j]) gnt_idx_o = Idx_Width'(j % Num_Ch);
    any_o = |req_i;
    gnt_o = any_o ? ({{(Num_Ch-1){1'b0}}, 1'b1} << gnt_idx_o) : '0;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N:1 round-robin arbitrating mux with valid/ready handshake.
// Define RR_ARB_MUX_OUT_REG_EN to add a registered output stage (latency 1).
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter  int Data_Width = 32,
  parameter  int Num_Ch     = 4,
  localparam int Idx_Width  = idx_width(Num_Ch)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [Num_Ch-1:0]            in_valid_i,
  input  logic [Num_Ch*Data_Width-1:0] in_data_i,
  output logic [Num_Ch-1:0]            in_ready_o,
  output logic                         out_valid_o,
  output logic [Data_Width-1:0]        out_data_o,
  output logic [Idx_Width-1:0]         out_ch_o,
  input  logic                         out_ready_i
);

  state_e                 state_q, state_d;
  logic [Idx_Width-1:0]   last_ptr_q, last_ptr_d;
  logic [Idx_Width-1:0]   lock_idx_q, lock_idx_d;

  logic [Num_Ch-1:0]      arb_gnt;
  logic [Idx_Width-1:0]   arb_idx;
  logic                   arb_any;

  logic [Num_Ch-1:0]      grant_oh;
  logic [Idx_Width-1:0]   grant_idx;
  logic                   sel_valid;
  logic [Data_Width-1:0]  sel_data;
  logic                   xfer;

  rr_arbiter #(.Num_Ch(Num_Ch)) u_arb (
    .req_i      (in_valid_i),
    .last_ptr_i (last_ptr_q),
    .gnt_o      (arb_gnt),
    .gnt_idx_o  (arb_idx),
    .any_o      (arb_any)
  );

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      last_ptr_q <= Idx_Width'(Num_Ch-1);
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // output/grant comb: HOLD pins the grant to the latched index
  always_comb begin
    if (state_q == HOLD) begin
      grant_idx = lock_idx_q;
      grant_oh  = {{(Num_Ch-1){1'b0}}, 1'b1} << lock_idx_q;
      sel_valid = 1'b1;
    end else begin
      grant_idx = arb_idx;
      grant_oh  = arb_gnt;
      sel_valid = arb_any;
    end
    sel_data = '0;
    for (int i = 0; i < Num_Ch; i++)
      if (sel_valid && grant_idx == Idx_Width'(i)) sel_data = in_data_i[i*Data_Width +: Data_Width];
  end

`ifdef RR_ARB_MUX_OUT_REG_EN
  logic                  out_valid_q;
  logic [Data_Width-1:0] out_data_q;
  logic [Idx_Width-1:0]  out_ch_q;
  logic                  load;

  assign load        = !out_valid_q || out_ready_i;
  assign in_ready_o  = grant_oh & {Num_Ch{load}};
  assign xfer        = sel_valid && load;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (load) begin
      out_valid_q <= sel_valid;
      out_data_q  <= sel_data;
      out_ch_q    <= sel_valid ? grant_idx : '0;
    end
  end

  // the output register absorbs back-pressure, so the arbiter never holds
  always_comb begin
    state_d    = ARB;
    lock_idx_d = lock_idx_q;
    last_ptr_d = xfer ? grant_idx : last_ptr_q;
  end
`else
  assign in_ready_o  = grant_oh & {Num_Ch{out_ready_i}};
  assign xfer        = sel_valid && out_ready_i;
  assign out_valid_o = sel_valid;
  assign out_data_o  = sel_data;
  assign out_ch_o    = sel_valid ? grant_idx : '0;

  // next-state comb
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    last_ptr_d = xfer ? grant_idx : last_ptr_q;
    case (state_q)
      ARB: if (sel_valid && !out_ready_i) begin
        state_d    = HOLD;
        lock_idx_d = grant_idx;
      end
      HOLD: if (out_ready_i) state_d = ARB;
      default: state_d = ARB;
    endcase
  end
`endif

endmodule
